booth_seq_multiplier: RTL and testbench
=======================================

# booth_seq_multiplier

Iterative signed radix-4 Booth multiplier: one multiplier digit is recoded per cycle through the existing `booth_encoder` block, and the selected partial product (0, ±A, ±2A) is accumulated into a 2·WIDTH-bit register. It is the stage that feeds `booth_encoder` its 3-bit codes and consumes its `neg`/`zero`/`one`/`two` outputs. It serves area-constrained datapaths where a full partial-product array is too large. Operands enter and results leave through valid/ready handshakes.

## Interface
- `WIDTH`, default 8: signed operand width. Must be even and ≥ 4. Iteration count N = WIDTH/2.
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept an operand pair.
- `a` input WIDTH: multiplicand, two's complement.
- `b` input WIDTH: multiplier, two's complement.
- `out_valid` output 1: `product` valid.
- `out_ready` input 1: consumer accepts `product`.
- `product` output 2·WIDTH: signed a·b, exact.
- `busy` output 1: high in CALC or DONE.

## Operation
- Reset is asynchronous and active-high. On reset: state IDLE, iteration counter 0, accumulator 0, `product` 0, `out_valid` 0, `busy` 0, `in_ready` 1.
- FSM states:
  - IDLE: `in_ready`=1. When `in_valid & in_ready`, go to CALC and latch:
    - mcand = sign-extend(a) to 2·WIDTH;
    - mshift = {b, 1'b0} (WIDTH+1 bits);
    - acc = 0, cnt = 0.
  - CALC: each cycle, code = mshift[2:0] drives `booth_encoder`. Partial product pp selection:
    - pp = mcand if `one`;
    - pp = mcand<<1 if `two`;
    - pp = 0 if `zero`;
    - if `neg`, pp = ~pp + 1.
    - Register updates: acc ← acc + pp (mod 2^(2·WIDTH)); mcand ← mcand<<2; mshift ← arithmetic shift right by 2 (sign-fill from b[WIDTH-1]); cnt ← cnt+1.
    - After the N-th update, go to DONE and register `product` = final acc.
  - DONE: `out_valid`=1 and `product` is held stable. On `out_valid & out_ready`, go to IDLE.
- `in_ready` is 0 in CALC and DONE. `in_valid` is ignored there, and operands are not re-sampled.
- Codes 000 and 111 select zero, and `neg` is never applied with zero, so there is no +1 artefact.
- Arithmetic: all sums are taken modulo 2^(2·WIDTH). The result is exact for all operand pairs, including (−2^(WIDTH−1))², which fits in 2·WIDTH signed bits.
- Reset asserted mid-CALC or mid-DONE aborts immediately: the result is lost and the block returns to reset values.
- `out_ready` high before `out_valid` has no effect.

## Timing
- Acceptance at edge k puts the block in CALC from k through k+N−1 and in DONE after edge k+N.
- `out_valid` rises N cycles after the accepting edge (4 for WIDTH=8).
- If `out_ready` is high when `out_valid` is high at edge m, the block is in IDLE with `in_ready`=1 after edge m. The next acceptance is possible at edge m+1.
- Peak throughput is one result per N+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.

## Configuration
- `BOOTH_SEQ_EARLY_TERM_EN` defined:
  - At the start of each CALC cycle, if the remaining mshift bits are all 0 or all 1, the remaining codes are zero. In that case `product` = acc is registered and the block enters DONE at that edge, skipping the remaining iterations.
  - Latency is variable, between 1 and N cycles.
  - Example: b=0 gives 1 cycle; b=−1 gives 1 cycle after the first code (111→zero… handled as all-ones).
- Not defined: latency is always exactly N cycles. No early-termination logic is synthesised.

## Test plan
- WIDTH=8, a=7, b=−3, `out_ready`=1 → `out_valid` 4 cycles after acceptance, `product`=16'hFFEB (−21).
- a=−128, b=−128 → `product`=16'h4000. a=127, b=−128 → 16'hC080.
- Hold `out_ready`=0 for 10 cycles after `out_valid` → `product` stable, `in_ready`=0, a new `in_valid` pulse is ignored. Raising `out_ready` → IDLE on the next edge, and the next operand pair is accepted one cycle later.
- Assert `rst` two cycles into CALC (a=5, b=9) → `out_valid`=0, `product`=0, `in_ready`=1 immediately. A fresh a=5, b=9 yields 16'h002D.
- Randomised back-to-back stream of 1000 pairs with random `in_valid`/`out_ready` gaps → every `product` equals the signed reference multiply, in order, with none dropped or duplicated.
- With `BOOTH_SEQ_EARLY_TERM_EN`: a=5, b=1 → `out_valid` 2 cycles after acceptance, `product`=5. a=5, b=0 → 1 cycle, `product`=0. Without the macro, both cases take 4 cycles.

Source files
------------

// File: rtl/booth_seq_multiplier.sv
// rtl/booth_seq_multiplier.sv - iterative signed radix-4 Booth multiplier with valid/ready handshakes
// Optional BOOTH_SEQ_EARLY_TERM_EN: finish as soon as the remaining multiplier digits all recode to zero.

module booth_encoder (
    input  logic [2:0] code,
    output logic       neg,
    output logic       zero,
    output logic       one,
    output logic       two
);
    assign zero = (code == 3'b000) || (code == 3'b111);
    assign one  = code[1] ^ code[0];
    assign two  = (code == 3'b011) || (code == 3'b100);
    // Only the -1/-2 codes set neg, so it never pairs with a zero selection.
    assign neg  = code[2] & ~(code[1] & code[0]);
endmodule

module booth_seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);
    localparam int N     = WIDTH / 2;
    localparam int P     = 2 * WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [P-1:0]       acc_q, acc_d;
    logic [P-1:0]       mcand_q, mcand_d;
    logic [WIDTH:0]     mshift_q, mshift_d;
    logic [P-1:0]       product_q, product_d;

    logic               enc_neg, enc_zero, enc_one, enc_two;
    logic [P-1:0]       pp_mag, pp, acc_sum;
    logic               early;
    logic               last_iter;

    booth_encoder u_enc (
        .code (mshift_q[2:0]),
        .neg  (enc_neg),
        .zero (enc_zero),
        .one  (enc_one),
        .two  (enc_two)
    );

    always_comb begin
        pp_mag = '0;
        if (!enc_zero) begin
            if (enc_one) begin
                pp_mag = mcand_q;
            end else if (enc_two) begin
                pp_mag = mcand_q << 1;
            end
        end
        pp      = enc_neg ? (~pp_mag + {{(P-1){1'b0}}, 1'b1}) : pp_mag;
        acc_sum = acc_q + pp;
    end

`ifdef BOOTH_SEQ_EARLY_TERM_EN
    // mshift is sign-filled, so all-equal bits mean every remaining code is 000 or 111.
    assign early = (mshift_q == '0) || (mshift_q == '1);
`else
    assign early = 1'b0;
`endif

    assign last_iter = early || (cnt_q == CNT_W'(N - 1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mshift_d  = mshift_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d  = S_CALC;
                    mcand_d  = {{WIDTH{a[WIDTH-1]}}, a};
                    mshift_d = {b, 1'b0};
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_CALC: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 2;
                mshift_d = {{2{mshift_q[WIDTH]}}, mshift_q[WIDTH:2]};
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    state_d   = S_DONE;
                    product_d = acc_sum;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mshift_q  <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mshift_q  <= mshift_d;
            product_q <= product_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign product   = product_q;
endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb/tb_booth_seq_multiplier.sv - directed and streaming checks for booth_seq_multiplier (WIDTH=8)

module tb_booth_seq_multiplier;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    booth_seq_multiplier #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called #1 after an edge with the DUT idle; optionally completes the output handshake.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic [15:0] exp_p, input int exp_lat, input bit release_out);
        int lat;
        a = ta;
        b = tb;
        in_valid = 1'b1;
        check_eq({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_product"}, product, exp_p);
        check_eq({tag, "_busy_done"}, busy, 1);
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check_eq({tag, "_idle_after"}, in_ready, 1);
        end
    endtask

    logic [15:0] expq[$];
    logic [15:0] pe;
    int sent, recv, cyc;
    bit acc_now, cons_now;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_product", product, 0);
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // out_ready high before out_valid must not matter
        out_ready = 1'b1;
        run_op("m7x_3", 8'd7, 8'hFD, 16'hFFEB, ET ? 3 : 4, 1'b1);
        run_op("m128sq", 8'h80, 8'h80, 16'h4000, 4, 1'b0);

        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 8'd3;
                b = 8'd3;
                in_valid = 1'b1;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            check_eq("hold_product", product, 16'h4000);
            check_eq("hold_in_ready", in_ready, 0);
            check_eq("hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_eq("release_in_ready", in_ready, 1);
        check_eq("release_out_valid", out_valid, 0);
        run_op("m127x_128", 8'h7F, 8'h80, 16'hC080, 4, 1'b1);

        a = 8'd5;
        b = 8'd9;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_out_valid", out_valid, 0);
        check_eq("abort_product", product, 0);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("m5x9", 8'd5, 8'd9, 16'h002D, 4, 1'b1);

        run_op("m5x1", 8'd5, 8'd1, 16'h0005, ET ? 2 : 4, 1'b1);
        run_op("m5x0", 8'd5, 8'd0, 16'h0000, ET ? 1 : 4, 1'b1);

        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 1000 && cyc < 30000) begin
            if (!in_valid && sent < 1000 && $urandom_range(3) != 0) begin
                a = 8'($urandom);
                b = 8'($urandom);
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(2) != 0);
            acc_now  = in_valid && in_ready;
            cons_now = out_valid && out_ready;
            if (cons_now) begin
                if (expq.size() == 0) begin
                    check_eq("stream_unexpected", 1, 0);
                end else begin
                    check_eq("stream_product", product, expq.pop_front());
                end
                recv++;
            end
            if (acc_now) begin
                pe = 16'($signed(a)) * 16'($signed(b));
                expq.push_back(pe);
                sent++;
            end
            @(posedge clk); #1;
            if (acc_now) in_valid = 1'b0;
            cyc++;
        end
        out_ready = 1'b0;
        check_eq("stream_count", recv, 1000);
        check_eq("stream_leftover", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
